// File: rtl/mul4_vector_pkg.sv
// mul4_vector_pkg: shared limb widths, types and enums for the mul4_vector family
package mul4_vector_pkg;
   localparam int LIMB_W  = 16;
   localparam int Q_LIMBS = 2;
   localparam int ITER    = Q_LIMBS * LIMB_W;
   localparam int CNT_W   = $clog2(ITER);
   typedef logic [LIMB_W-1:0] limb_t;
   typedef enum logic [1:0] {ERR_OK = 2'b00, ERR_DIV0 = 2'b01, ERR_OVF = 2'b10} err_t;
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/mul4_div_step.sv
// mul4_div_step: one combinational restoring-division step (rem, qsr, d) -> (rem', qsr')
module mul4_div_step
   import mul4_vector_pkg::*;
(
   input  logic [ITER:0]   rem,
   input  logic [ITER-1:0] qsr,
   input  logic [ITER-1:0] d,
   output logic [ITER:0]   rem_n,
   output logic [ITER-1:0] qsr_n
);
   logic [ITER:0] t;
   logic          ge;
   always_comb begin
      t     = {rem[ITER-1:0], qsr[ITER-1]};
      ge    = rem[ITER] | (t >= {1'b0, d});
      rem_n = ge ? t - {1'b0, d} : t;
      qsr_n = {qsr[ITER-2:0], ge};
   end
endmodule

// File: rtl/mul4_vector_divider.sv
// mul4_vector_divider: 64/32 sequential restoring divider, one quotient bit per clock,
// valid/ready on both sides; error results bypass the iteration entirely.
module mul4_vector_divider
   import mul4_vector_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [LIMB_W-1:0] n3,
   input  logic [LIMB_W-1:0] n2,
   input  logic [LIMB_W-1:0] n1,
   input  logic [LIMB_W-1:0] n0,
   input  logic [LIMB_W-1:0] d1,
   input  logic [LIMB_W-1:0] d0,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LIMB_W-1:0] q1,
   output logic [LIMB_W-1:0] q0,
   output logic [LIMB_W-1:0] rm1,
   output logic [LIMB_W-1:0] rm0,
   output logic [1:0]        err
);
   state_t            state_q, state_d;
   err_t              err_q, err_d;
   logic [ITER:0]     rem_q, rem_d, rem_n;
   logic [ITER-1:0]   qsr_q, qsr_d, qsr_n;
   logic [ITER-1:0]   dv_q, dv_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2*ITER-1:0] n;
   logic [ITER-1:0]   dv;
   mul4_div_step u_step (
      .rem   (rem_q),
      .qsr   (qsr_q),
      .d     (dv_q),
      .rem_n (rem_n),
      .qsr_n (qsr_n)
   );
   always_comb begin
      n       = {n3, n2, n1, n0};
      dv      = {d1, d0};
      state_d = state_q;
      err_d   = err_q;
      rem_d   = rem_q;
      qsr_d   = qsr_q;
      dv_d    = dv_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: if (in_valid) begin
            dv_d  = dv;
            cnt_d = '0;
            if (dv == '0) begin
               state_d = S_DONE;
               err_d   = ERR_DIV0;
               qsr_d   = '1;
               rem_d   = {1'b0, n[ITER-1:0]};
            end else if (n[2*ITER-1:ITER] >= dv) begin
               // quotient would not fit in ITER bits
               state_d = S_DONE;
               err_d   = ERR_OVF;
               qsr_d   = '1;
               rem_d   = '0;
            end else begin
               state_d = S_RUN;
               err_d   = ERR_OK;
               rem_d   = {1'b0, n[2*ITER-1:ITER]};
               qsr_d   = n[ITER-1:0];
            end
         end
         S_RUN: begin
            rem_d   = rem_n;
            qsr_d   = qsr_n;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (cnt_q == CNT_W'(ITER - 1)) ? S_DONE : S_RUN;
         end
         S_DONE: state_d = out_ready ? S_IDLE : S_DONE;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         err_q   <= ERR_OK;
         rem_q   <= '0;
         qsr_q   <= '0;
         dv_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         rem_q   <= rem_d;
         qsr_q   <= qsr_d;
         dv_q    <= dv_d;
         cnt_q   <= cnt_d;
      end
   end
   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = (state_q == S_DONE);
   assign {q1, q0}   = qsr_q;
   assign {rm1, rm0} = rem_q[ITER-1:0];
   assign err        = err_q;
endmodule

// File: doc/mul4_vector_divider.md
Name: mul4_vector_divider

Overview:
- Sequential restoring divider, the inverse of the mul4_vector multiplier: takes a 4-limb (64-bit) product and a 2-limb (32-bit) divisor, and returns a 2-limb quotient and a 2-limb remainder.
- Used as the golden inverse checker on product outputs, and as a reusable divide unit on the same 16-bit limb vector interface.
- Input and output use valid/ready handshakes; the block computes one quotient bit per clock.

Parameters:
- LIMB_W, 16, width of one limb.
- Q_LIMBS, 2, quotient/divisor limbs; ITER = Q_LIMBS*LIMB_W = 32 iterations.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- n3,n2,n1,n0  input  LIMB_W each  dividend limbs, n3 most significant.
- d1,d0  input  LIMB_W each  divisor limbs, d1 most significant.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- q1,q0  output  LIMB_W each  quotient limbs.
- rm1,rm0  output  LIMB_W each  remainder limbs.
- err  output  2  00 ok, 01 divide-by-zero, 10 quotient overflow.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, q*/rm*/err = 0.
- Reset mid-operation aborts the current division. The result is discarded and the block is in IDLE on the next cycle.
- State IDLE: in_ready=1. An accept (in_valid & in_ready) latches N={n3,n2,n1,n0} and D={d1,d0}.
  - If D==0: go to DONE with err=01, q=32'hFFFF_FFFF, rm=N[31:0].
  - Else if N[63:32] >= D: go to DONE with err=10, q=32'hFFFF_FFFF, rm=0.
  - Otherwise: rem(33b)={1'b0,N[63:32]}, qsr=N[31:0], cnt=0, go to RUN.
- State RUN: in_ready=0. Each cycle:
  - t={rem[31:0],qsr[31]}.
  - If t>=D: rem=t-D and shift 1 into qsr. Else rem=t and shift 0 into qsr.
  - cnt++. When cnt reaches ITER-1, go to DONE.
- State DONE: out_valid=1, q={qsr}, rm=rem[31:0].
  - Outputs stay stable until out_ready. out_valid & out_ready returns to IDLE.
  - No new operand is accepted in the same cycle as the output handshake.
- Latency, accept cycle counted as cycle 0:
  - Normal operation: out_valid rises in cycle ITER+1 (33).
  - Error cases: out_valid rises in cycle 1.
- Throughput: one division per ITER+2 cycles when out_ready is tied high.
- Widths:
  - Comparison and subtraction use a 33-bit remainder. The remainder is always < D after each step.
  - Arithmetic is unsigned; there is no sign handling.
- in_valid while busy is ignored, since in_ready=0. Operands must be re-presented until accepted.
- Invariant for err=00: Q*D + R == N and R < D. The bench checks this on every result.

Decomposition:
- Shared package mul4_vector_pkg:
  - LIMB_W.
  - typedef limb_t.
  - enum err_t {ERR_OK, ERR_DIV0, ERR_OVF}.
  - enum state_t {S_IDLE, S_RUN, S_DONE}.
- One natural sub-module: mul4_div_step. It is purely combinational: one restoring step mapping (rem, qsr, D) to (rem', qsr').
- The top level holds the FSM, counter, operand registers and handshake.

Test Plan:
- N=0x0000_0003_000A_0008, D=0x0003_0004 -> q1=0x0001, q0=0x0002, rm=0, err=00; out_valid exactly 33 cycles after accept.
- N=0x0000_0003_000A_000D, D=0x0003_0004 -> q=0x0001_0002, rm1=0x0000, rm0=0x0005, err=00.
- N=0xFFFF_FFFE_0000_0001, D=0xFFFF_FFFF -> q=0xFFFF_FFFF, rm=0, err=00. This is the max-operand case with no false overflow.
- D=0, N=0x1111_2222_3333_4444 -> err=01, q=0xFFFF_FFFF, rm1=0x3333, rm0=0x4444, out_valid 1 cycle after accept.
- N=0x0000_0001_0000_0000, D=1 -> err=10, q=0xFFFF_FFFF, rm=0.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles after DONE -> outputs stable and in_ready=0 throughout.
  - Assert rst in RUN cycle 15 -> next cycle out_valid=0, in_ready=1.
  - A following division then completes correctly.
